multicycle_sequencer: RTL and testbench

//  Moore FSM that sequences the shared MIPS datapath (PC, IR, reg bank, ALU, unified memory) over multiple cycles per instruction.

---
 rtl/mips_pkg.sv | 77 +++++++
 rtl/seq_wait_timer.sv | 37 +++
 rtl/multicycle_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//  - state_e      : sequencer state encoding (also exported on the debug port)
//  - OP_* / FN_*  : opcode and funct values the sequencer decodes
//  - select codes : reg_dst, mem_to_reg, pc_src, alu_op, ALU source muxes
//  - decode_next  : DECODE-state dispatch from opcode to the next state
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   // opcodes (IR[31:26]) and funct (IR[5:0])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // write-register select
   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   // write-data select
   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   // next-PC select
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU operand selects and memory address select
   localparam logic       SRCA_PC   = 1'b0;
   localparam logic       SRCA_RS   = 1'b1;
   localparam logic [1:0] SRCB_RT   = 2'd0;
   localparam logic [1:0] SRCB_ONE  = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic       ADDR_PC   = 1'b0;
   localparam logic       ADDR_ALU  = 1'b1;

   // DECODE dispatch; anything not listed is illegal and traps
   function automatic state_e decode_next(input logic [5:0] op);
      state_e nxt;
      case (op)
         OP_RTYPE:     nxt = S_EXEC_R;
         OP_ADDI:      nxt = S_EXEC_I;
         OP_LW, OP_SW: nxt = S_MEM_ADDR;
         OP_BEQ:       nxt = S_BRANCH;
         OP_J, OP_JAL: nxt = S_JUMP;
         default:      nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-wait watchdog for the multicycle sequencer.
// Counts consecutive cycles a memory request is pending without mem_ready
// and flags the cycle in which the wait reaches TIMEOUT.
//  clock      in  system clock
//  reset      in  synchronous active-high reset
//  pending_i  in  request outstanding and mem_ready low this cycle
//  timeout_o  out this is the TIMEOUT-th consecutive waiting cycle
module seq_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic pending_i,
   output logic timeout_o
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   // any cycle without a stalled request (ready seen, idle, or another
   // state) restarts the count
   always_comb begin
      cnt_d = 8'd0;
      if (pending_i) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end

   // cnt_q holds the number of earlier waiting cycles, so this cycle is
   // the TIMEOUT-th one when cnt_q == TIMEOUT-1
   assign timeout_o = pending_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control sequencer.
// Steps the shared datapath (PC, IR, reg bank, ALU, unified memory) through
// fetch/decode/execute/memory/writeback, one memory port for both fetch and
// load/store with a ready handshake. Counts retired instructions and traps
// (sticky) on illegal opcodes or memory timeouts.
//  clock, reset          clock / synchronous active-high reset
//  run                   allow fetching the next instruction
//  opcode, funct         IR fields, valid from DECODE onward
//  zero                  ALU zero flag (beq)
//  mem_ready             memory completes the request this cycle
//  pc_write .. pc_src    datapath enables and mux selects
//  state                 current state (debug)
//  instr_done            pulse on the last cycle of each instruction
//  retired               retired-instruction count (wraps)
//  trap                  sticky trap flag
module multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired,
   output logic             trap
);

   import mips_pkg::*;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   retired_q;
   logic               trap_q;
   logic               mem_wait;
   logic               timeout;

   // a request is outstanding in FETCH (only while running) and in the two
   // data-access states; mem_ready anywhere else is ignored
   assign mem_wait = ((state_q == S_FETCH) && run) ||
                     (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   seq_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .pending_i (mem_wait && !mem_ready),
      .timeout_o (timeout)
   );

   // next state and outputs; everything stays at its default while reset is
   // high so no write fires in a reset cycle
   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = ADDR_PC;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = REGDST_RT;
      mem_to_reg = M2R_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RT;
      alu_op     = ALUOP_ADD;
      pc_src     = PCSRC_ALU;
      instr_done = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               if (run) begin
                  mem_read  = 1'b1;
                  i_or_d    = ADDR_PC;
                  alu_src_a = SRCA_PC;
                  alu_src_b = SRCB_ONE;
                  pc_src    = PCSRC_ALU;
                  if (mem_ready) begin
                     ir_write = 1'b1;
                     pc_write = 1'b1;
                     state_d  = S_DECODE;
                  end else if (timeout) begin
                     state_d  = S_TRAP;
                  end
               end
            end
            S_DECODE: begin
               // ALUOut <= PC+1 + imm, the beq target
               alu_src_a = SRCA_PC;
               alu_src_b = SRCB_IMM;
               alu_op    = ALUOP_ADD;
               state_d   = decode_next(opcode);
            end
            S_EXEC_R: begin
               if (funct == FN_JR) begin
                  pc_write   = 1'b1;
                  pc_src     = PCSRC_RS;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  alu_src_a = SRCA_RS;
                  alu_src_b = SRCB_RT;
                  alu_op    = ALUOP_FUNCT;
                  state_d   = S_WB_ALU;
               end
            end
            S_EXEC_I: begin
               alu_src_a = SRCA_RS;
               alu_src_b = SRCB_IMM;
               alu_op    = ALUOP_ADD;
               state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
               // shared by R-type and addi; IR still selects the destination
               reg_write  = 1'b1;
               reg_dst    = (opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
               mem_to_reg = M2R_ALUOUT;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
               alu_src_a = SRCA_RS;
               alu_src_b = SRCB_IMM;
               alu_op    = ALUOP_ADD;
               state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               i_or_d   = ADDR_ALU;
               mem_read = 1'b1;
               if (mem_ready)    state_d = S_WB_MEM;
               else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WR: begin
               i_or_d    = ADDR_ALU;
               mem_write = 1'b1;
               if (mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else if (timeout) begin
                  state_d    = S_TRAP;
               end
            end
            S_WB_MEM: begin
               reg_write  = 1'b1;
               reg_dst    = REGDST_RT;
               mem_to_reg = M2R_MDR;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_BRANCH: begin
               // the subtract drives zero this cycle; taken branch loads ALUOut
               alu_src_a  = SRCA_RS;
               alu_src_b  = SRCB_RT;
               alu_op     = ALUOP_SUB;
               pc_src     = PCSRC_ALUOUT;
               pc_write   = zero;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_JUMP: begin
               pc_write   = 1'b1;
               pc_src     = PCSRC_JUMP;
               instr_done = 1'b1;
               // PC already holds PC+1, so the link value is taken from PC
               if (opcode == OP_JAL) begin
                  reg_write  = 1'b1;
                  reg_dst    = REGDST_RA;
                  mem_to_reg = M2R_PC;
               end
               state_d    = S_FETCH;
            end
            S_TRAP: begin
               state_d = S_TRAP;
            end
            default: begin
               state_d = S_TRAP;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
         trap_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (instr_done)         retired_q <= retired_q + CNT_W'(1);
         if (state_d == S_TRAP)  trap_q    <= 1'b1;
      end
   end

   assign state   = state_q;
   assign retired = retired_q;
   assign trap    = trap_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
   import mips_pkg::*;

   logic        clock = 1'b0;
   logic        reset, run, zero, mem_ready;
   logic [5:0]  opcode, funct;
   logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
   logic        alu_src_a, instr_done, trap;
   logic [3:0]  state;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int c0, n, viol;

   multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_src(pc_src), .state(state), .instr_done(instr_done),
      .retired(retired), .trap(trap)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #2;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // run one instruction from FETCH with mem_ready=1 until instr_done
   task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int exp_n, input logic exp_wr, input logic exp_rw);
      int k;
      logic done, both, wr, rw;
      opcode = op; funct = fn; #1;
      k = 0; done = 0; both = 0; wr = 0; rw = 0;
      while (!done && k < 20) begin
         k++;
         both |= mem_read & mem_write;
         wr   |= mem_write;
         rw   |= reg_write;
         done  = instr_done;
         tick();
      end
      chk({tag, "_cycles"}, k, exp_n);
      chk({tag, "_rdwr_both"}, 32'(both), 0);
      chk({tag, "_memwrite"}, 32'(wr), 32'(exp_wr));
      chk({tag, "_regwrite"}, 32'(rw), 32'(exp_rw));
   endtask

   initial begin
      reset = 1; run = 1; mem_ready = 1; opcode = 0; funct = 0; zero = 0;
      tick();
      chk("rst_state", state, S_FETCH);
      chk("rst_en", {pc_write, ir_write, mem_read, mem_write, reg_write, instr_done}, 0);
      chk("rst_retired", retired, 0);
      chk("rst_trap", trap, 0);
      tick(); tick();

      // 1: R-type add, 4 cycles
      reset = 0; opcode = OP_RTYPE; funct = 6'b100000; #1;
      c0 = cyc;
      chk("r_f_state", state, S_FETCH);
      chk("r_f_en", {mem_read, ir_write, pc_write, i_or_d}, 4'b1110);
      chk("r_f_srcb", alu_src_b, 1);
      tick();
      chk("r_d_state", state, S_DECODE);
      chk("r_d_srcb", alu_src_b, 2);
      chk("r_d_pcw", pc_write, 0);
      tick();
      chk("r_e_state", state, S_EXEC_R);
      chk("r_e_ctl", {alu_src_a, alu_op, reg_write}, 4'b1100);
      tick();
      chk("r_wb_state", state, S_WB_ALU);
      chk("r_wb_ctl", {reg_write, reg_dst, instr_done}, 4'b1011);
      tick();
      chk("r_cycles", cyc - c0, 4);
      chk("r_retired", retired, 1);

      // 2: lw with 3 stall cycles in MEM_RD, 8 cycles
      opcode = OP_LW; #1;
      c0 = cyc;
      chk("lw_f_state", state, S_FETCH);
      tick();
      chk("lw_d_state", state, S_DECODE);
      tick();
      chk("lw_ma_state", state, S_MEM_ADDR);
      chk("lw_ma_src", {alu_src_a, alu_src_b}, 3'b110);
      mem_ready = 0; #1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("lw_mr_state", state, S_MEM_RD);
         chk("lw_mr_ctl", {mem_read, mem_write, i_or_d}, 3'b101);
         tick();
      end
      mem_ready = 1; #1;
      chk("lw_mr4_state", state, S_MEM_RD);
      chk("lw_mr4_ctl", {mem_read, mem_write, i_or_d}, 3'b101);
      tick();
      chk("lw_wb_state", state, S_WB_MEM);
      chk("lw_wb_ctl", {reg_write, reg_dst, mem_to_reg, instr_done}, 6'b100011);
      tick();
      chk("lw_cycles", cyc - c0, 8);
      chk("lw_retired", retired, 2);

      // 3: beq taken then not taken
      opcode = OP_BEQ; zero = 1; #1;
      c0 = cyc;
      tick(); tick();
      chk("beq1_state", state, S_BRANCH);
      chk("beq1_ctl", {pc_write, pc_src, alu_op, instr_done}, 6'b101011);
      tick();
      chk("beq1_cycles", cyc - c0, 3);
      zero = 0; #1;
      c0 = cyc;
      tick(); tick();
      chk("beq0_ctl", {pc_write, pc_src, alu_op, instr_done}, 6'b001011);
      tick();
      chk("beq0_cycles", cyc - c0, 3);
      chk("beq_retired", retired, 4);

      // 4: jal then jr
      opcode = OP_JAL; #1;
      tick(); tick();
      chk("jal_state", state, S_JUMP);
      chk("jal_ctl", {pc_write, reg_write, reg_dst, mem_to_reg, pc_src, instr_done}, 9'b11_10_10_10_1);
      tick();
      opcode = OP_RTYPE; funct = FN_JR; #1;
      tick(); tick();
      chk("jr_state", state, S_EXEC_R);
      chk("jr_ctl", {pc_write, pc_src, reg_write, instr_done}, 5'b1_11_0_1);
      tick();
      chk("jr_retired", retired, 6);

      // remaining cycle counts with mem_ready tied high
      do_instr("addi", OP_ADDI, 6'd0, 4, 1'b0, 1'b1);
      do_instr("sw",   OP_SW,   6'd0, 4, 1'b1, 1'b0);
      do_instr("j",    OP_J,    6'd0, 3, 1'b0, 1'b0);
      do_instr("lw1",  OP_LW,   6'd0, 5, 1'b0, 1'b1);
      chk("mix_retired", retired, 10);

      // 5: illegal opcode traps and stays quiet
      opcode = 6'b111111; #1;
      tick(); tick();
      chk("ill_state", state, S_TRAP);
      chk("ill_trap", trap, 1);
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         if ({pc_write, ir_write, mem_read, mem_write, reg_write, instr_done} !== 6'b0 ||
             state !== S_TRAP || trap !== 1'b1) viol++;
         tick();
      end
      chk("ill_quiet", viol, 0);
      chk("ill_retired", retired, 10);
      reset = 1; tick(); reset = 0; #1;
      chk("ill_rst_state", state, S_FETCH);
      chk("ill_rst_trap", trap, 0);
      chk("ill_rst_retired", retired, 0);

      // reset in WB_ALU suppresses the write and the retire
      opcode = OP_ADDI; #1;
      tick(); tick(); tick();
      chk("mid_state", state, S_WB_ALU);
      reset = 1; #1;
      chk("mid_en", {reg_write, instr_done, pc_write}, 0);
      tick();
      reset = 0; #1;
      chk("mid_after_state", state, S_FETCH);
      chk("mid_after_retired", retired, 0);

      // 6: fetch timeout after exactly 15 cycles
      mem_ready = 0; #1;
      n = 0;
      while (state !== S_TRAP && n < 40) begin
         tick();
         n++;
      end
      chk("to_cycles", n, 15);
      chk("to_trap", trap, 1);
      reset = 1; run = 0; tick(); reset = 0; #1;
      viol = 0;
      for (int i = 0; i < 30; i++) begin
         if (mem_read || mem_write || trap || state !== S_FETCH) viol++;
         tick();
      end
      chk("idle_quiet", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
